seq_mult_param: RTL and testbench
=================================

Name: seq_mult_param

Overview:
Parametrised sequential shift-and-add multiplier, the successor to the 16-bit repeated-addition multiplier. It adds a configurable operand width, a runtime signed/unsigned mode, a full-width 2*WIDTH product, optional early termination, and a start/busy/done handshake. It sits as a shared arithmetic unit behind any controller that issues one multiply at a time.

Parameters:
WIDTH, 16, operand width in bits (>=2); product is 2*WIDTH.
EARLY_EXIT, 1, 1 = stop iterating once the remaining multiplier bits are all zero; 0 = always WIDTH iterations.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  request a multiply; sampled only when busy=0.
signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; captured with start.
a  in  WIDTH  multiplicand; captured with start.
b  in  WIDTH  multiplier; captured with start.
busy  out  1  high from the edge after start is accepted until done deasserts.
done  out  1  one-cycle pulse; product is valid from this cycle on.
product  out  2*WIDTH  result; held until the next done.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, product=0; all internal registers cleared. Reset during CALC or DONE aborts the operation with no done pulse.
- FSM states and transitions:
  - IDLE -> CALC on a clk edge with start=1.
  - CALC -> DONE when the exit condition holds.
  - DONE -> IDLE unconditionally.
- Capture (start acceptance edge, edge 0):
  - If signed_mode=1, store magnitudes |a| and |b| in WIDTH-bit registers. |-2^(WIDTH-1)| = 2^(WIDTH-1) fits unsigned.
  - Store neg = signed_mode & (a[MSB] ^ b[MSB]).
  - acc=0, mcand = zero-extended |a| (2*WIDTH bits), mplr = |b|, cnt=0.
- Each CALC edge:
  - If mplr[0], acc <= acc + mcand (2*WIDTH bits, no overflow possible).
  - Then mcand <<= 1, mplr >>= 1, cnt++.
- Exit condition, evaluated on post-update values: cnt==WIDTH, or (EARLY_EXIT=1 and the shifted mplr==0). At least one iteration always runs, so b=0 takes 1 iteration.
- Iteration count N:
  - EARLY_EXIT=1: N = index of the highest set bit of |b| + 1 (1 when b=0).
  - EARLY_EXIT=0: N = WIDTH.
- DONE edge: product <= neg ? -acc : acc (2*WIDTH two's complement); done=1 for exactly that cycle.
- Latency: done is high in the cycle following edge N+1; busy is high in the cycles following edges 0..N+1.
- start while busy=1 (CALC or DONE) is ignored; no queuing.
- start held high continuously: a new operation is accepted on the edge after done deasserts, i.e. back-to-back with one IDLE cycle.
- Operand inputs are don't-care after capture; changing them mid-operation has no effect.
- busy and done are registered outputs; no combinational path from inputs to outputs.

Decomposition:
- Shared package seq_mult_pkg: FSM state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2) and the default WIDTH constant.
- One sub-module, seq_mult_ctrl: the FSM and iteration counter. It outputs load, step and finish strobes.
- Datapath registers and adder live in the top module, seq_mult_param.

Test Plan:
- WIDTH=16, EARLY_EXIT=1, unsigned, a=3, b=5 -> N=3; done after edge 4; product=0x0000000F; busy high for 5 cycles.
- Unsigned a=0xFFFF, b=0xFFFF -> N=16; product=0xFFFE0001; done after edge 17. Same operands with EARLY_EXIT=0 give identical timing.
- Signed a=0xFFFD (-3), b=5 -> product=0xFFFFFFF1. Signed a=0x8000, b=0x8000 -> product=0x40000000.
- b=0, a=0x1234, either mode -> N=1; product=0; done after edge 2. With EARLY_EXIT=0, done after edge 17.
- Issue start (a=2, b=7), then pulse start with a=9, b=9 during CALC -> second request ignored; product=14; a later start in IDLE yields 81.
- Deassert rst_n mid-CALC -> busy, done and product go to 0 immediately, with no done pulse. After release, a new start (a=6, b=7) yields 42.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_e;

    localparam int DEFAULT_WIDTH      = 16;
    localparam int DEFAULT_EARLY_EXIT = 1;

    // Counter width able to hold the value WIDTH itself.
    function automatic int cnt_bits(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_mult_ctrl.sv
// Sequencing for the multiplier: FSM, iteration counter and the busy/done handshake.
module seq_mult_ctrl
    import seq_mult_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int EARLY_EXIT = DEFAULT_EARLY_EXIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic mplr_rest_zero,
    output logic load,
    output logic step,
    output logic finish,
    output logic busy,
    output logic done
);

    localparam int CW = cnt_bits(WIDTH);

    mult_state_e   state, state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          last_iter;

    assign cnt_next  = cnt + 1'b1;
    // Exit is judged on the values this step produces, so b=0 still costs one pass.
    assign last_iter = (cnt_next == CW'(WIDTH)) ||
                       ((EARLY_EXIT != 0) && mplr_rest_zero);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && !busy) state_next = CALC;
            CALC:    if (last_iter)      state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load   = 1'b0;
        step   = 1'b0;
        finish = 1'b0;
        case (state)
            IDLE:    load   = start && !busy;
            CALC:    step   = 1'b1;
            DONE:    finish = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    cnt <= '0;
        else if (load) cnt <= '0;
        else if (step) cnt <= cnt_next;
    end

    // busy spans the done cycle, which is what blocks a held start for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= finish;
            if (load)      busy <= 1'b1;
            else if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_mult_param.sv
// Parametrised sequential shift-and-add multiplier with signed/unsigned mode and early exit.
module seq_mult_param
    import seq_mult_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int EARLY_EXIT = DEFAULT_EARLY_EXIT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int PW = 2 * WIDTH;

    logic             load, step, finish;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] mplr;
    logic [PW-1:0]    acc, mcand, acc_sum;
    logic             neg;
    logic             mplr_rest_zero;

    seq_mult_ctrl #(
        .WIDTH      (WIDTH),
        .EARLY_EXIT (EARLY_EXIT)
    ) u_ctrl (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .mplr_rest_zero (mplr_rest_zero),
        .load           (load),
        .step           (step),
        .finish         (finish),
        .busy           (busy),
        .done           (done)
    );

    // Negating the most negative value wraps to 2^(WIDTH-1), which reads correctly as unsigned.
    assign mag_a = (signed_mode && a[WIDTH-1]) ? -a : a;
    assign mag_b = (signed_mode && b[WIDTH-1]) ? -b : b;

    assign mplr_rest_zero = (mplr[WIDTH-1:1] == '0);
    assign acc_sum        = acc + mcand;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            mcand <= '0;
            mplr  <= '0;
            neg   <= 1'b0;
        end else if (load) begin
            acc   <= '0;
            mcand <= {{WIDTH{1'b0}}, mag_a};
            mplr  <= mag_b;
            neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (step) begin
            if (mplr[0]) acc <= acc_sum;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      product <= '0;
        else if (finish) product <= neg ? -acc : acc;
    end

endmodule

// File: tb/tb_seq_mult_param.sv
// Randomised self-checking bench for seq_mult_param, early-exit and full-iteration builds side by side.
module tb_seq_mult_param;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          signed_mode = 1'b0;
    logic [W-1:0]  a = '0, b = '0;
    logic          busy1, done1, busy0, done0;
    logic [2*W-1:0] prod1, prod0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_mult_param #(.WIDTH(W), .EARLY_EXIT(1)) dut_ee (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy1), .done(done1), .product(prod1)
    );

    seq_mult_param #(.WIDTH(W), .EARLY_EXIT(0)) dut_full (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy0), .done(done0), .product(prod0)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_prod(input logic sm, input logic [W-1:0] av, input logic [W-1:0] bv);
        longint pa, pb, p;
        pa = sm ? longint'($signed(av)) : longint'(av);
        pb = sm ? longint'($signed(bv)) : longint'(bv);
        p  = pa * pb;
        return p[2*W-1:0];
    endfunction

    function automatic int ref_iters(input logic sm, input logic [W-1:0] bv, input bit ee);
        logic [W-1:0] mag;
        int n;
        if (!ee) return W;
        mag = (sm && bv[W-1]) ? -bv : bv;
        n = 1;
        for (int i = 0; i < W; i++) if (mag[i]) n = i + 1;
        return n;
    endfunction

    task automatic run_op(input logic sm, input logic [W-1:0] av, input logic [W-1:0] bv, input bit inject);
        logic [2*W-1:0] exp;
        int n1, n0, kmax, d1, d0, dc1, dc0;
        bit bz1, bz0;
        exp  = ref_prod(sm, av, bv);
        n1   = ref_iters(sm, bv, 1'b1);
        n0   = ref_iters(sm, bv, 1'b0);
        kmax = n0 + 3;
        @(negedge clk);
        signed_mode = sm; a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = W'($urandom); b = W'($urandom); signed_mode = 1'($urandom);
        d1 = -1; d0 = -1; dc1 = 0; dc0 = 0; bz1 = 1'b1; bz0 = 1'b1;
        for (int k = 0; k <= kmax; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (inject && k == 1) begin start = 1'b1; a = 9; b = 9; signed_mode = 1'b0; end
            if (inject && k == 2) start = 1'b0;
            if (busy1 !== (k <= n1 + 1)) bz1 = 1'b0;
            if (busy0 !== (k <= n0 + 1)) bz0 = 1'b0;
            if (done1 === 1'b1) begin dc1++; if (d1 < 0) d1 = k; end
            if (done0 === 1'b1) begin dc0++; if (d0 < 0) d0 = k; end
        end
        chk($sformatf("lat_ee a=%h b=%h s=%b", av, bv, sm), 64'(d1), 64'(n1 + 1));
        chk($sformatf("lat_full a=%h b=%h s=%b", av, bv, sm), 64'(d0), 64'(n0 + 1));
        chk("done_pulses_ee", 64'(dc1), 64'd1);
        chk("done_pulses_full", 64'(dc0), 64'd1);
        chk("busy_window_ee", 64'(bz1), 64'd1);
        chk("busy_window_full", 64'(bz0), 64'd1);
        chk($sformatf("prod_ee a=%h b=%h s=%b", av, bv, sm), 64'(prod1), 64'(exp));
        chk($sformatf("prod_full a=%h b=%h s=%b", av, bv, sm), 64'(prod0), 64'(exp));
    endtask

    initial begin
        int dcount;
        logic [W-1:0] rb;
        #12;
        chk("reset_busy", 64'({busy1, busy0}), 64'd0);
        chk("reset_done", 64'({done1, done0}), 64'd0);
        chk("reset_prod", 64'(prod1 | prod0), 64'd0);
        @(negedge clk); rst_n = 1'b1;

        run_op(1'b0, 16'd3, 16'd5, 1'b0);
        run_op(1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
        run_op(1'b1, 16'hFFFD, 16'd5, 1'b0);
        run_op(1'b1, 16'h8000, 16'h8000, 1'b0);
        run_op(1'b0, 16'h1234, 16'd0, 1'b0);
        run_op(1'b1, 16'h1234, 16'd0, 1'b0);
        run_op(1'b0, 16'd2, 16'd7, 1'b1);
        run_op(1'b0, 16'd9, 16'd9, 1'b0);

        for (int i = 0; i < 24; i++) begin
            rb = W'($urandom) >> $urandom_range(0, W - 1);
            if (i % 5 == 0) rb = W'($urandom);
            run_op(1'($urandom), W'($urandom), rb, 1'b0);
        end

        // start held high: early-exit unit re-accepts after exactly one idle cycle
        @(negedge clk);
        signed_mode = 1'b0; a = 16'd3; b = 16'd5; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k == 5) chk("hold_idle_gap", 64'(busy1), 64'd0);
            if (k == 6) chk("hold_reaccept", 64'(busy1), 64'd1);
        end
        start = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (!busy1 && !busy0) break;
            @(posedge clk); #1;
        end
        chk("hold_drain_idle", 64'({busy1, busy0}), 64'd0);
        chk("hold_prod_ee", 64'(prod1), 64'd15);
        chk("hold_prod_full", 64'(prod0), 64'd15);

        // asynchronous reset mid-calculation
        @(negedge clk);
        signed_mode = 1'b0; a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        #2; rst_n = 1'b0; #1;
        chk("arst_busy", 64'({busy1, busy0}), 64'd0);
        chk("arst_done", 64'({done1, done0}), 64'd0);
        chk("arst_prod", 64'(prod1 | prod0), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done1 || done0 || busy1 || busy0) dcount++;
        end
        chk("arst_no_done", 64'(dcount), 64'd0);
        run_op(1'b0, 16'd6, 16'd7, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
